// File: rtl/apb_master_dec.sv
// rtl/apb_master_dec.sv - APB master: decodes the slave from the top address bits and times out stalled accesses.
// Optional macro APB_SLVERR_EN adds the per-slave apb_slverr_in port and reports PSLVERR as the transfer error.
module apb_master_dec #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int SLAVE_DEVICES  = 4,
  parameter int TIMEOUT_CYCLE  = 6
) (
  input  logic                                    apb_clk_in,
  input  logic                                    apb_rstn_in,
  output logic [APB_ADDR_WIDTH-1:0]               apb_addr_out,
  output logic [SLAVE_DEVICES-1:0]                apb_psel_out,
  output logic                                    apb_penable_out,
  output logic                                    apb_write_out,
  output logic [APB_DATA_WIDTH-1:0]               apb_wdata_out,
  input  logic [SLAVE_DEVICES*APB_DATA_WIDTH-1:0] apb_rdata_in,
  input  logic [SLAVE_DEVICES-1:0]                apb_ready_in,
`ifdef APB_SLVERR_EN
  input  logic [SLAVE_DEVICES-1:0]                apb_slverr_in,
`endif
  input  logic                                    other_req_in,
  input  logic [APB_ADDR_WIDTH-1:0]               other_addr_in,
  input  logic                                    other_write_in,
  input  logic [APB_DATA_WIDTH-1:0]               other_wdata_in,
  output logic                                    other_busy_out,
  output logic                                    other_done_out,
  output logic                                    other_error_out,
  output logic [APB_DATA_WIDTH-1:0]               other_rdata_out
);

  localparam int SEL_WIDTH = (SLAVE_DEVICES > 1) ? $clog2(SLAVE_DEVICES) : 1;
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLE + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                    state, state_nxt;
  logic [SEL_WIDTH-1:0]      req_idx, idx;
  logic                      idx_valid;
  logic [CNT_W-1:0]          cnt;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      err_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      sel_ready;
  logic [APB_DATA_WIDTH-1:0] sel_rdata;
  logic [SLAVE_DEVICES-1:0]  psel_dec;
  logic                      timeout_hit;
`ifdef APB_SLVERR_EN
  logic                      sel_err;
`endif

  if (SLAVE_DEVICES == 1) begin : g_one
    assign req_idx = '0;
  end else begin : g_multi
    assign req_idx = other_addr_in[APB_ADDR_WIDTH-1 -: SEL_WIDTH];
  end

  assign idx_valid   = ({1'b0, req_idx} < (SEL_WIDTH+1)'(SLAVE_DEVICES));
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLE - 1));

  // Only the registered slave's PREADY/PRDATA/PSLVERR reach the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    psel_dec  = '0;
`ifdef APB_SLVERR_EN
    sel_err   = 1'b0;
`endif
    for (int i = 0; i < SLAVE_DEVICES; i++) begin
      if (idx == SEL_WIDTH'(i)) begin
        psel_dec[i] = 1'b1;
        sel_ready   = apb_ready_in[i];
        sel_rdata   = apb_rdata_in[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
`ifdef APB_SLVERR_EN
        sel_err     = apb_slverr_in[i];
`endif
      end
    end
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    apb_psel_out    = '0;
    apb_penable_out = 1'b0;
    other_done_out  = 1'b0;
    other_busy_out  = 1'b1;
    case (state)
      IDLE: begin
        other_busy_out = 1'b0;
        if (other_req_in) state_nxt = idx_valid ? SETUP : DONE;
      end
      SETUP: begin
        apb_psel_out = psel_dec;
        state_nxt    = ACCESS;
      end
      ACCESS: begin
        apb_psel_out    = psel_dec;
        apb_penable_out = 1'b1;
        if (sel_ready || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        other_done_out = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counting and result latching; results change only on entry to DONE.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      idx     <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (other_req_in) begin
            addr_q  <= other_addr_in;
            write_q <= other_write_in;
            wdata_q <= other_write_in ? other_wdata_in : '0;
            idx     <= req_idx;
            cnt     <= '0;
            if (!idx_valid) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            rdata_q <= write_q ? '0 : sel_rdata;
`ifdef APB_SLVERR_EN
            err_q   <= sel_err;
`else
            err_q   <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (timeout_hit) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        DONE: cnt <= '0;
        default: ;
      endcase
    end
  end

  assign apb_addr_out    = addr_q;
  assign apb_write_out   = write_q;
  assign apb_wdata_out   = wdata_q;
  assign other_error_out = err_q;
  assign other_rdata_out = rdata_q;

endmodule

// File: tb/tb_apb_master_dec.sv
// tb/tb_apb_master_dec.sv - table-driven and randomized bench for apb_master_dec.
// Honours APB_SLVERR_EN when defined.
module tb_apb_master_dec;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int T  = 6;
`ifdef APB_SLVERR_EN
  localparam logic SE_ERR = 1'b1;
`else
  localparam logic SE_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          req = 1'b0, req3 = 1'b0, write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [N*DW-1:0] rdata_in = '0;
  logic [N-1:0]  ready_in = '0;
  logic [N-1:0]  slverr_in = '0;
  logic [AW-1:0] paddr;
  logic [N-1:0]  psel;
  logic          penable, pwrite, busy, done, err;
  logic [DW-1:0] pwdata, rdata;

  logic [3*DW-1:0] rdata3_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  logic [2:0]    ready3 = 3'b111;
  logic [2:0]    slverr3 = 3'b000;
  logic [AW-1:0] paddr3;
  logic [2:0]    psel3;
  logic          penable3, pwrite3, busy3, done3, err3;
  logic [DW-1:0] pwdata3, rdata3;

  apb_master_dec #(.APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .SLAVE_DEVICES(N), .TIMEOUT_CYCLE(T)) dut (
    .apb_clk_in(clk), .apb_rstn_in(rstn),
    .apb_addr_out(paddr), .apb_psel_out(psel), .apb_penable_out(penable),
    .apb_write_out(pwrite), .apb_wdata_out(pwdata),
    .apb_rdata_in(rdata_in), .apb_ready_in(ready_in),
`ifdef APB_SLVERR_EN
    .apb_slverr_in(slverr_in),
`endif
    .other_req_in(req), .other_addr_in(addr), .other_write_in(write), .other_wdata_in(wdata),
    .other_busy_out(busy), .other_done_out(done), .other_error_out(err), .other_rdata_out(rdata)
  );

  apb_master_dec #(.APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .SLAVE_DEVICES(3), .TIMEOUT_CYCLE(T)) dut3 (
    .apb_clk_in(clk), .apb_rstn_in(rstn),
    .apb_addr_out(paddr3), .apb_psel_out(psel3), .apb_penable_out(penable3),
    .apb_write_out(pwrite3), .apb_wdata_out(pwdata3),
    .apb_rdata_in(rdata3_in), .apb_ready_in(ready3),
`ifdef APB_SLVERR_EN
    .apb_slverr_in(slverr3),
`endif
    .other_req_in(req3), .other_addr_in(addr), .other_write_in(write), .other_wdata_in(wdata),
    .other_busy_out(busy3), .other_done_out(done3), .other_error_out(err3), .other_rdata_out(rdata3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Unselected slaves get random PREADY/PRDATA/PSLVERR so that any leakage shows up.
  task automatic drive_slaves(input int s, input logic rdy, input logic [DW-1:0] rd, input logic se);
    ready_in  = N'($urandom);
    slverr_in = N'($urandom);
    for (int i = 0; i < N; i++) rdata_in[i*DW +: DW] = $urandom;
    ready_in[s]  = rdy;
    slverr_in[s] = se;
    rdata_in[s*DW +: DW] = rd;
  endtask

  // Reference: slave from the top two address bits, latency 3 + waits unless waits reach T.
  task automatic model(input logic [AW-1:0] a, input logic w, input int waits, input logic [DW-1:0] rd,
                       input logic se, output int lat, output logic e, output logic [DW-1:0] r,
                       output logic [N-1:0] ps);
    ps = N'(1) << a[AW-1 -: 2];
    if (waits < T) begin
      lat = 3 + waits;
      e   = se & SE_ERR;
      r   = w ? '0 : rd;
    end else begin
      lat = 2 + T;
      e   = 1'b1;
      r   = '0;
    end
  endtask

  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd, input int waits,
                      input logic [DW-1:0] rd, input logic se, input logic spam,
                      input int lat, input logic e, input logic [DW-1:0] r, input logic [N-1:0] ps);
    int s;
    int got;
    s = int'(a[AW-1 -: 2]);
    got = -1;
    @(negedge clk);
    addr = a; write = w; wdata = wd; req = 1'b1;
    drive_slaves(s, 1'b0, rd, se);
    for (int c = 1; c <= 20 && got < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("setup_psel", psel, ps);
        chk("setup_penable", penable, 0);
        chk("setup_addr", paddr, a);
        chk("setup_write", pwrite, w);
        chk("setup_wdata", pwdata, w ? wd : '0);
      end
      if (c == 2) begin
        chk("access_psel", psel, ps);
        chk("access_penable", penable, 1);
      end
      if (done) begin
        got = c;
        chk("done_psel", psel, 0);
        chk("done_penable", penable, 0);
        chk("done_busy", busy, 1);
      end
      req = spam;
      if (spam) begin
        addr = $urandom; write = 1'($urandom); wdata = $urandom;
      end
      drive_slaves(s, c >= 2 + waits, rd, se);
    end
    chk("latency", got, lat);
    chk("error", err, e);
    chk("rdata", rdata, r);
    @(negedge clk);
    req = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_err_hold", err, e);
    chk("post_rdata_hold", rdata, r);
    chk("post_addr_hold", paddr, a);
  endtask

  task automatic xfer3(input logic [AW-1:0] a, input int lat, input logic e, input logic [DW-1:0] r,
                       input logic [2:0] ps);
    int got;
    logic [2:0] seen;
    got = -1;
    seen = '0;
    @(negedge clk);
    addr = a; write = 1'b0; req3 = 1'b1;
    for (int c = 1; c <= 10 && got < 0; c++) begin
      @(negedge clk);
      req3 = 1'b0;
      seen |= psel3;
      if (done3) got = c;
    end
    chk("dec_latency", got, lat);
    chk("dec_error", err3, e);
    chk("dec_rdata", rdata3, r);
    chk("dec_psel_seen", seen, ps);
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] wd;
    int            waits;
    logic [DW-1:0] rd;
    logic          se;
    logic          spam;
    int            lat;
    logic          e;
    logic [DW-1:0] r;
    logic [N-1:0]  ps;
  } vec_t;

  vec_t vt[6];

  initial begin
    int nd;
    int lat;
    logic e;
    logic [DW-1:0] r;
    logic [N-1:0] ps;
    logic [AW-1:0] a;
    logic w, se, spam;
    logic [DW-1:0] wd, rd;
    int waits;

    vt[0] = '{32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 0,  32'hAAAA_5555, 1'b0, 1'b0, 3, 1'b0,   32'h0,         4'b0010};
    vt[1] = '{32'h8000_0020, 1'b0, 32'h1111_1111, 3,  32'h1234_5678, 1'b0, 1'b0, 6, 1'b0,   32'h1234_5678, 4'b0100};
    vt[2] = '{32'h0000_0004, 1'b0, 32'h0,         99, 32'hCAFE_F00D, 1'b0, 1'b0, 8, 1'b1,   32'h0,         4'b0001};
    vt[3] = '{32'hC000_0000, 1'b0, 32'h0,         5,  32'h0BAD_F00D, 1'b0, 1'b1, 8, 1'b0,   32'h0BAD_F00D, 4'b1000};
    vt[4] = '{32'hC000_0008, 1'b1, 32'h5A5A_5A5A, 6,  32'h0000_0077, 1'b0, 1'b0, 8, 1'b1,   32'h0,         4'b1000};
    vt[5] = '{32'h4000_0000, 1'b0, 32'h0,         1,  32'h600D_D00D, 1'b1, 1'b1, 4, SE_ERR, 32'h600D_D00D, 4'b0010};

    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", paddr, 0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++)
      xfer(vt[i].a, vt[i].w, vt[i].wd, vt[i].waits, vt[i].rd, vt[i].se, vt[i].spam,
           vt[i].lat, vt[i].e, vt[i].r, vt[i].ps);

    for (int i = 0; i < 40; i++) begin
      a = $urandom; w = 1'($urandom); wd = $urandom; rd = $urandom;
      waits = $urandom_range(0, 8); se = 1'($urandom); spam = 1'($urandom);
      model(a, w, waits, rd, se, lat, e, r, ps);
      xfer(a, w, wd, waits, rd, se, spam, lat, e, r, ps);
    end

    xfer3(32'hC000_0000, 1, 1'b1, 32'h0, 3'b000);
    xfer3(32'h8000_0000, 3, 1'b0, 32'h3333_3333, 3'b100);

    // Abort mid-ACCESS with an asynchronous reset; no completion may follow.
    @(negedge clk);
    addr = 32'h4000_0000; write = 1'b1; wdata = 32'hFFFF_FFFF; req = 1'b1;
    drive_slaves(1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("pre_rst_penable", penable, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_psel", psel, 0);
    chk("async_penable", penable, 0);
    chk("async_busy", busy, 0);
    chk("async_addr", paddr, 0);
    chk("async_write", pwrite, 0);
    chk("async_wdata", pwdata, 0);
    chk("async_err", err, 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_abort", nd, 0);
    chk("idle_after_abort", busy, 0);
    xfer(32'h8000_0040, 1'b0, 32'h0, 2, 32'h0102_0304, 1'b0, 1'b0, 5, 1'b0, 32'h0102_0304, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
